poly_bank_mem: RTL and testbench

- Four-bank polynomial coefficient store that sits directly downstream of the NTT/INTT/PWM address generator.
- Consumes the generator's four 7-bit lane addresses every cycle and returns the four addressed words one cycle later to the butterfly array.
- Re-applies the same addresses, delayed to match the butterfly pipeline, as write addresses when the delayed write enable arrives.
- A host port loads and unloads the polynomial while the engine is idle.

---
 rtl/poly_bank_mem.sv | 173 +++++++++++++++++
 tb/tb_poly_bank_mem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : poly_bank_mem
// Description : Four-bank polynomial coefficient store with lane crossbar,
//               delayed write-back addressing and a host load/unload port.
//               Optional macro POLY_BANK_CONFLICT_CHECK_EN adds conflict_err.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_bank_mem #(
    parameter int WORD_W    = 24,
    parameter int SHORT_DLY = 4,
    parameter int LONG_DLY  = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [6:0]        addr0,
    input  logic [6:0]        addr1,
    input  logic [6:0]        addr2,
    input  logic [6:0]        addr3,
    input  logic              wen,
    input  logic              wb_short,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    input  logic [WORD_W-1:0] wdata2,
    input  logic [WORD_W-1:0] wdata3,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic [WORD_W-1:0] rdata2,
    output logic [WORD_W-1:0] rdata3,
    input  logic              host_sel,
    input  logic              host_we,
    input  logic [6:0]        host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic [WORD_W-1:0] host_rdata
`ifdef POLY_BANK_CONFLICT_CHECK_EN
    ,
    output logic              conflict_err
`endif
);

    localparam int c_LANES = 4;
    localparam int c_BANKS = 4;
    localparam int c_ROWS  = 32;

    // Parity of the upper address bits spreads every butterfly quad over all banks.
    function automatic logic [1:0] f_bank(input logic [6:0] a);
        return {a[0], ^a[6:1]};
    endfunction

    logic [c_LANES-1:0][6:0]        w_addr;
    logic [c_LANES-1:0][WORD_W-1:0] w_wdata;
    logic [c_LANES-1:0][6:0]        w_wr_addr;
    logic [c_LANES-1:0][1:0]        w_lane_bank;
    logic [c_LANES-1:0][1:0]        w_wr_bank;
    logic [1:0]                     w_host_bank;

    logic [c_BANKS-1:0][4:0]        w_rd_row;
    logic [c_BANKS-1:0]             w_we;
    logic [c_BANKS-1:0][4:0]        w_wr_row;
    logic [c_BANKS-1:0][WORD_W-1:0] w_wr_data;
    logic [c_BANKS-1:0][WORD_W-1:0] w_bank_rd;

    logic [c_LANES-1:0][6:0]        r_dly [LONG_DLY];
    logic [c_BANKS-1:0][WORD_W-1:0] r_bank_q;
    logic [c_LANES-1:0][1:0]        r_lane_sel;
    logic [WORD_W-1:0]              r_host_rdata;

    assign w_addr      = {addr3, addr2, addr1, addr0};
    assign w_wdata     = {wdata3, wdata2, wdata1, wdata0};
    assign w_wr_addr   = wb_short ? r_dly[SHORT_DLY-1] : r_dly[LONG_DLY-1];
    assign w_host_bank = f_bank(host_addr);

    generate
        for (genvar n = 0; n < c_LANES; n++) begin : g_lane
            assign w_lane_bank[n] = f_bank(w_addr[n]);
            assign w_wr_bank[n]   = f_bank(w_wr_addr[n]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LONG_DLY; i++) r_dly[i] <= '0;
        end else if (!host_sel) begin
            r_dly[0] <= w_addr;
            for (int i = 1; i < LONG_DLY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Lanes are scanned high to low so the lowest lane owns a contended bank port.
    always_comb begin
        w_rd_row  = '0;
        w_we      = '0;
        w_wr_row  = '0;
        w_wr_data = '0;
        if (host_sel) begin
            for (int b = 0; b < c_BANKS; b++) w_rd_row[b] = host_addr[6:2];
            w_we[w_host_bank]      = host_we;
            w_wr_row[w_host_bank]  = host_addr[6:2];
            w_wr_data[w_host_bank] = host_wdata;
        end else begin
            for (int n = c_LANES - 1; n >= 0; n--) begin
                w_rd_row[w_lane_bank[n]] = w_addr[n][6:2];
                if (wen) begin
                    w_we[w_wr_bank[n]]      = 1'b1;
                    w_wr_row[w_wr_bank[n]]  = w_wr_addr[n][6:2];
                    w_wr_data[w_wr_bank[n]] = w_wdata[n];
                end
            end
        end
    end

    generate
        for (genvar b = 0; b < c_BANKS; b++) begin : g_bank
            logic [WORD_W-1:0] r_mem [c_ROWS];

            always_ff @(posedge clk) begin
                if (w_we[b] && rstn) r_mem[w_wr_row[b]] <= w_wr_data[b];
            end

            assign w_bank_rd[b] = r_mem[w_rd_row[b]];
        end
    endgenerate

    // Bank outputs and lane selects freeze in host mode so rdata holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bank_q     <= '0;
            r_lane_sel   <= '0;
            r_host_rdata <= '0;
        end else if (host_sel) begin
            r_host_rdata <= w_bank_rd[w_host_bank];
        end else begin
            r_bank_q   <= w_bank_rd;
            r_lane_sel <= w_lane_bank;
        end
    end

    assign rdata0     = r_bank_q[r_lane_sel[0]];
    assign rdata1     = r_bank_q[r_lane_sel[1]];
    assign rdata2     = r_bank_q[r_lane_sel[2]];
    assign rdata3     = r_bank_q[r_lane_sel[3]];
    assign host_rdata = r_host_rdata;

`ifdef POLY_BANK_CONFLICT_CHECK_EN
    function automatic logic f_clash(input logic [c_LANES-1:0][1:0] bk);
        logic c;
        c = 1'b0;
        for (int i = 0; i < c_LANES; i++)
            for (int j = i + 1; j < c_LANES; j++)
                if (bk[i] == bk[j]) c = 1'b1;
        return c;
    endfunction

    logic w_rd_clash;
    logic w_wr_clash;
    logic r_conflict;

    assign w_rd_clash = f_clash(w_lane_bank);
    assign w_wr_clash = f_clash(w_wr_bank);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_conflict <= 1'b0;
        end else if (!host_sel && (w_rd_clash || (wen && w_wr_clash))) begin
            r_conflict <= 1'b1;
        end
    end

    assign conflict_err = r_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_poly_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_bank_mem
// Description : Directed scoreboard bench for poly_bank_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_bank_mem;

    localparam int WORD_W = 24;

    logic              clk;
    logic              rstn;
    logic [6:0]        addr0, addr1, addr2, addr3;
    logic              wen;
    logic              wb_short;
    logic [WORD_W-1:0] wdata0, wdata1, wdata2, wdata3;
    logic [WORD_W-1:0] rdata0, rdata1, rdata2, rdata3;
    logic              host_sel;
    logic              host_we;
    logic [6:0]        host_addr;
    logic [WORD_W-1:0] host_wdata;
    logic [WORD_W-1:0] host_rdata;
`ifdef POLY_BANK_CONFLICT_CHECK_EN
    logic              conflict_err;
`endif

    poly_bank_mem #(
        .WORD_W   (WORD_W),
        .SHORT_DLY(4),
        .LONG_DLY (7)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .addr3     (addr3),
        .wen       (wen),
        .wb_short  (wb_short),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .wdata2    (wdata2),
        .wdata3    (wdata3),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rdata3    (rdata3),
        .host_sel  (host_sel),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata)
`ifdef POLY_BANK_CONFLICT_CHECK_EN
        ,
        .conflict_err(conflict_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_assert = 0;
    int                n_fail   = 0;
    logic [WORD_W-1:0] exp_q[$];
    string             tag_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [WORD_W-1:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [WORD_W-1:0] obs);
        string             t;
        logic [WORD_W-1:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed %0d with nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic quad(input logic [6:0] a0, input logic [6:0] a1,
                        input logic [6:0] a2, input logic [6:0] a3);
        addr0 = a0; addr1 = a1; addr2 = a2; addr3 = a3;
    endtask

    task automatic wdat(input int d0, input int d1, input int d2, input int d3);
        wdata0 = WORD_W'(d0); wdata1 = WORD_W'(d1);
        wdata2 = WORD_W'(d2); wdata3 = WORD_W'(d3);
    endtask

    task automatic expect_lanes(input string tag, input int e0, input int e1,
                                input int e2, input int e3);
        push({tag, "_r0"}, WORD_W'(e0));
        push({tag, "_r1"}, WORD_W'(e1));
        push({tag, "_r2"}, WORD_W'(e2));
        push({tag, "_r3"}, WORD_W'(e3));
    endtask

    task automatic check_lanes();
        pop_check(rdata0);
        pop_check(rdata1);
        pop_check(rdata2);
        pop_check(rdata3);
    endtask

    task automatic host_read(input string tag, input logic [6:0] a, input int e);
        host_sel  = 1'b1;
        host_we   = 1'b0;
        host_addr = a;
        push(tag, WORD_W'(e));
        tick();
        pop_check(host_rdata);
    endtask

    initial begin
        rstn = 1'b0; wen = 1'b0; wb_short = 1'b0;
        host_sel = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        quad(0, 0, 0, 0);
        wdat(0, 0, 0, 0);
        tick();
        tick();

        // Reset state
        expect_lanes("reset", 0, 0, 0, 0);
        check_lanes();
        push("reset_host_rdata", '0);
        pop_check(host_rdata);
        rstn = 1'b1;
        tick();

        // Host load of address+100
        host_we = 1'b1;
        for (int a = 0; a < 128; a++) begin
            host_addr  = 7'(a);
            host_wdata = WORD_W'(a + 100);
            tick();
        end
        host_we = 1'b0;
        for (int a = 0; a < 128; a++) begin
            host_addr = 7'(a);
            push("host_load_rd", WORD_W'(a + 100));
            tick();
            pop_check(host_rdata);
        end
        expect_lanes("host_mode_engine_idle", 0, 0, 0, 0);
        check_lanes();

        // Engine read of a butterfly quad
        host_sel = 1'b0;
        quad(8, 9, 12, 13);
        expect_lanes("engine_rd", 108, 109, 112, 113);
        tick();
        check_lanes();

        // Long write-back: quad at t, wen at t+7
        wb_short = 1'b0;
        quad(0, 1, 64, 65);
        tick();
        quad(8, 9, 12, 13);
        for (int k = 0; k < 6; k++) tick();
        wen = 1'b1;
        wdat(1, 2, 3, 4);
        tick();
        wen = 1'b0;
        host_read("long_wb_a0", 0, 1);
        host_read("long_wb_a1", 1, 2);
        host_read("long_wb_a64", 64, 3);
        host_read("long_wb_a65", 65, 4);
        host_read("long_wb_keep8", 8, 108);
        host_read("long_wb_keep13", 13, 113);

        // Short write-back: quad A at t (wen t+4), quad B at t+3 (wen t+7)
        host_sel = 1'b0;
        wb_short = 1'b1;
        quad(2, 3, 66, 67);
        tick();
        quad(8, 9, 12, 13);
        tick();
        tick();
        quad(24, 25, 28, 29);
        tick();
        quad(8, 9, 12, 13);
        wen = 1'b1;
        wdat(5, 6, 7, 8);
        tick();
        wen = 1'b0;
        tick();
        tick();
        wen = 1'b1;
        wdat(9, 10, 11, 12);
        tick();
        wen = 1'b0;
        host_read("short_wb_a2", 2, 5);
        host_read("short_wb_a3", 3, 6);
        host_read("short_wb_a66", 66, 7);
        host_read("short_wb_a67", 67, 8);
        host_read("short_wb_t3_a24", 24, 9);
        host_read("short_wb_t3_a29", 29, 12);
        host_read("short_wb_keep9", 9, 109);
        host_read("long_wb_survives_a0", 0, 1);

        // Read-before-write on address 20 (short path)
        host_sel = 1'b0;
        quad(20, 21, 22, 23);
        tick();
        quad(8, 9, 12, 13);
        tick();
        tick();
        tick();
        quad(20, 21, 22, 23);
        wen = 1'b1;
        wdat(500, 501, 502, 503);
        expect_lanes("rbw_old", 120, 121, 122, 123);
        tick();
        check_lanes();
        wen = 1'b0;
        expect_lanes("rbw_new", 500, 501, 502, 503);
        tick();
        check_lanes();

        // Asynchronous reset mid-cycle clears registers, memory is retained
        #3;
        rstn = 1'b0;
        #1;
        expect_lanes("async_rst", 0, 0, 0, 0);
        check_lanes();
        push("async_rst_host_rdata", '0);
        pop_check(host_rdata);
        tick();
        rstn = 1'b1;
        tick();
        host_read("mem_retained_a20", 20, 500);
        host_read("mem_retained_a64", 64, 3);

`ifdef POLY_BANK_CONFLICT_CHECK_EN
        push("conflict_after_reset", '0);
        pop_check(WORD_W'(conflict_err));
        host_sel = 1'b0;
        wb_short = 1'b0;
        quad(0, 1, 6, 3);
        push("conflict_set", WORD_W'(1));
        tick();
        pop_check(WORD_W'(conflict_err));
        quad(8, 9, 12, 13);
        push("conflict_sticky", WORD_W'(1));
        tick();
        pop_check(WORD_W'(conflict_err));
        #3;
        rstn = 1'b0;
        #1;
        push("conflict_async_clear", '0);
        pop_check(WORD_W'(conflict_err));
        tick();
        rstn = 1'b1;
        tick();
        push("conflict_stays_clear", '0);
        pop_check(WORD_W'(conflict_err));
`endif

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
